// File: rtl/add_ctrl_pkg.sv
// Shared definitions for the multi-word add/subtract controller:
// word width, FSM state encoding and the signed-overflow rule.
package add_ctrl_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } add_state_t;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        signed_ovf = (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/ripple16.sv
// 16-bit ripple-carry adder, purely combinational. Single shared
// arithmetic resource of the multi-word controller.
module ripple16
    import add_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_cin,
    output logic [WORD_W-1:0] o_s,
    output logic              o_cout
);

    logic [WORD_W:0] w_c;

    assign w_c[0] = i_cin;

    genvar g;
    generate
        for (g = 0; g < WORD_W; g++) begin : g_fa
            assign o_s[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
            assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
        end
    endgenerate

    assign o_cout = w_c[WORD_W];

endmodule

// File: rtl/multiword_add_ctrl.sv
// Multi-word adder/subtractor: operands are latched on start and then
// processed one 16-bit word per clock (LSW first) through one shared
// ripple16, with the carry chained between words in a register.
module multiword_add_ctrl
    import add_ctrl_pkg::*;
#(
    parameter int WORDS = 4
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    op_sub,
    input  logic [WORD_W*WORDS-1:0] a_in,
    input  logic [WORD_W*WORDS-1:0] b_in,
    input  logic                    cin,
    output logic [WORD_W*WORDS-1:0] sum,
    output logic                    cout,
    output logic                    ovf,
    output logic                    busy,
    output logic                    done
);

    localparam int DW    = WORD_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    add_state_t         r_state;
    add_state_t         w_next_state;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    logic [IDX_W-1:0]   r_idx;
    logic [DW-1:0]      r_a;
    logic [DW-1:0]      r_b;
    logic               r_carry;
    logic [DW-1:0]      r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    // Bit offset of the current word; words are 16 bits so the offset is idx*16.
    logic [IDX_W+3:0]   w_base;
    logic [WORD_W-1:0]  w_a_word;
    logic [WORD_W-1:0]  w_b_word;
    logic [WORD_W-1:0]  w_s;
    logic               w_co;

    assign w_base   = {r_idx, 4'b0000};
    assign w_a_word = r_a[w_base +: WORD_W];
    assign w_b_word = r_b[w_base +: WORD_W];
    assign w_last   = (r_idx == IDX_LAST);

    ripple16 u_ripple16 (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_co)
    );

    // Next-state decode plus load/step strobes for the datapath.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_ADD;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ADD: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_ADD;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register with registered busy/done flags derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == ST_ADD);
            r_done  <= (w_next_state == ST_DONE);
        end
    end

    // Operand latch, word-serial accumulation and final flag capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= IDX_ZERO;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            // Subtract is A + ~B + 1: invert B here, seed the carry with 1.
            r_a     <= a_in;
            r_b     <= op_sub ? ~b_in : b_in;
            r_carry <= op_sub ? 1'b1 : cin;
            r_idx   <= IDX_ZERO;
        end else if (w_step) begin
            r_sum[w_base +: WORD_W] <= w_s;
            r_carry                 <= w_co;
            if (w_last) begin
                // Park the index at zero rather than stepping past the last word.
                r_idx  <= IDX_ZERO;
                r_cout <= w_co;
                r_ovf  <= signed_ovf(r_a[DW-1], r_b[DW-1], w_s[WORD_W-1]);
            end else begin
                r_idx  <= r_idx + IDX_ONE;
            end
        end else begin
            r_idx <= r_idx;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Self-checking bench for multiword_add_ctrl (WORDS=4, 64-bit operands).
// Expected results come from plain 64/66-bit arithmetic in the bench.
module tb_multiword_add_ctrl;

    localparam int W  = 4;
    localparam int DW = 16 * W;

    logic          clk;
    logic          rst;
    logic          start;
    logic          op_sub;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic          cin;
    logic [DW-1:0] sum;
    logic          cout;
    logic          ovf;
    logic          busy;
    logic          done;

    int n_tests;
    int n_fail;
    int done_cnt;
    int exp_done_cnt;

    logic [DW-1:0] prev_sum;
    logic          prev_cout;
    logic          prev_ovf;

    multiword_add_ctrl #(.WORDS(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .a_in   (a_in),
        .b_in   (b_in),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every observed done pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [DW-1:0] got,
                             input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Checks hold behaviour and the single-pulse done at the cycle after DONE.
    task automatic check_idle(input string tag);
        check_val({tag, "_done_low"}, {63'd0, done}, 64'd0);
        check_val({tag, "_sum_hold"}, sum, prev_sum);
        check_val({tag, "_cout_hold"}, {63'd0, cout}, {63'd0, prev_cout});
        check_val({tag, "_ovf_hold"}, {63'd0, ovf}, {63'd0, prev_ovf});
        check_val({tag, "_done_count"}, 64'(done_cnt), 64'(exp_done_cnt));
    endtask

    // One operation: drive start on a negedge, follow it to done, compare.
    // disturb=1 re-pulses start and scrambles inputs mid-operation.
    task automatic do_op(input string tag, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic sub,
                         input logic c, input logic disturb);
        logic [DW-1:0]      e_sum;
        logic               e_cout;
        logic               e_ovf;
        logic signed [DW+1:0] sr;
        logic [DW:0]        wide;
        int                 lat;
        bit                 got;

        if (sub) begin
            e_sum  = a - b;
            e_cout = (a >= b);
            sr     = {{2{a[DW-1]}}, a} - {{2{b[DW-1]}}, b};
        end else begin
            wide   = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
            e_sum  = wide[DW-1:0];
            e_cout = wide[DW];
            sr     = {{2{a[DW-1]}}, a} + {{2{b[DW-1]}}, b} + {{(DW+1){1'b0}}, c};
        end
        // Result fits in DW signed bits iff the top three bits agree.
        e_ovf = !((sr[DW+1:DW-1] == 3'b000) || (sr[DW+1:DW-1] == 3'b111));

        @(negedge clk);
        check_idle(tag);
        a_in   = a;
        b_in   = b;
        op_sub = sub;
        cin    = c;
        start  = 1'b1;

        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                lat = k;
            end
            if (k == 1) begin
                check_val({tag, "_busy"}, {63'd0, busy}, 64'd1);
            end
            start = 1'b0;
            if (disturb && k == 2) begin
                start  = 1'b1;
                a_in   = ~a;
                b_in   = {$urandom, $urandom};
                op_sub = ~sub;
                cin    = ~c;
            end
        end
        start = 1'b0;

        if (!got) begin
            check_val({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check_val({tag, "_latency"}, 64'(lat), 64'(W + 1));
            check_val({tag, "_sum"}, sum, e_sum);
            check_val({tag, "_cout"}, {63'd0, cout}, {63'd0, e_cout});
            check_val({tag, "_ovf"}, {63'd0, ovf}, {63'd0, e_ovf});
            check_val({tag, "_busy_off"}, {63'd0, busy}, 64'd0);
        end
        exp_done_cnt++;
        prev_sum  = e_sum;
        prev_cout = e_cout;
        prev_ovf  = e_ovf;
    endtask

    // Start an operation, then hit reset mid-way and check the async clear.
    task automatic reset_abort();
        @(negedge clk);
        check_idle("pre_abort");
        a_in   = 64'h1234_5678_9ABC_DEF0;
        b_in   = 64'h1111_1111_1111_1111;
        op_sub = 1'b0;
        cin    = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort_sum", sum, 64'd0);
        check_val("abort_flags", {60'd0, cout, ovf, busy, done}, 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        prev_sum  = '0;
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        done_cnt     = 0;
        exp_done_cnt = 0;
        prev_sum     = '0;
        prev_cout    = 1'b0;
        prev_ovf     = 1'b0;
        rst          = 1'b1;
        start        = 1'b0;
        op_sub       = 1'b0;
        a_in         = '0;
        b_in         = '0;
        cin          = 1'b0;

        #1;
        check_val("reset_sum", sum, 64'd0);
        check_val("reset_flags", {60'd0, cout, ovf, busy, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op("carry_word", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        do_op("wrap_all",   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        do_op("sub_neg",    64'h5, 64'h7, 1'b1, 1'b0, 1'b0);
        do_op("pos_ovf",    64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        do_op("cin_only",   64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        do_op("sub_cin_ig", 64'h9, 64'h2, 1'b1, 1'b1, 1'b0);
        do_op("neg_ovf",    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        do_op("sub_ovf",    64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 1'b0);
        do_op("disturb",    64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b1, 1'b1);

        reset_abort();
        do_op("after_rst",  64'h1, 64'h1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            do_op("rand", {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        @(negedge clk);
        check_idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 SHALL have parameter WORDS, default 4, giving the number of 16-bit words per operand (operand width 16*WORDS).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, a request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op_sub, input, 1, selecting the operation: 0 = A+B+cin, 1 = A-B.
REQ-006 SHALL have port a_in, input, 16*WORDS, operand A.
REQ-007 SHALL have port b_in, input, 16*WORDS, operand B.
REQ-008 SHALL have port cin, input, 1, the carry-in for add; ignored when op_sub=1.
REQ-009 SHALL have port sum, output, 16*WORDS, the registered result.
REQ-010 SHALL have port cout, output, 1, the final carry (for subtract: 1 = no borrow).
REQ-011 SHALL have port ovf, output, 1, two's-complement signed overflow of the full-width result.
REQ-012 SHALL have port busy, output, 1, high in ADD state.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse marking sum/cout/ovf valid.

Function
REQ-014 SHALL implement FSM states IDLE, ADD, DONE.
REQ-015 In IDLE with start=1, SHALL at the clock edge latch a_in, latch b_in (inverted when op_sub=1), set the carry register to (op_sub ? 1 : cin), set word index=0, and enter ADD.
REQ-016 In ADD, each edge SHALL feed word[index] of the latched A and B plus the carry register into one shared 16-bit ripple adder, write S into sum word[index], load Cout into the carry register, and increment index.
REQ-017 After the edge that processes index WORDS-1, SHALL enter DONE, drive cout from the carry register, and compute ovf = (A msb == B' msb) && (sum msb != A msb).
REQ-018 In DONE, SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency SHALL be fixed: with a start edge at cycle 0, done is high during cycle WORDS+1 (cycle 5 for WORDS=4).
REQ-020 start during ADD or DONE SHALL be ignored and not queued; input changes after the latch SHALL NOT affect the result.
REQ-021 sum, cout and ovf SHALL hold their values from done until the next accepted start; sum words not yet written SHALL keep prior values during ADD.
REQ-022 Back-to-back operation SHALL allow start to be accepted in the IDLE cycle immediately after DONE.
REQ-023 Index arithmetic SHALL be unsigned, of width clog2(WORDS), and SHALL never wrap past WORDS-1.

Reset
REQ-024 rst=1 SHALL immediately, independent of clk, force state=IDLE, index=0, carry=0, sum=0, cout=0, ovf=0, busy=0, done=0.
REQ-025 Reset mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be served normally.

Structure
REQ-026 SHALL place the state encoding (IDLE/ADD/DONE) and the word width constant 16 in a shared package, add_ctrl_pkg.
REQ-027 SHALL instantiate exactly one existing ripple16 sub-module as the sole adder; no other arithmetic on the data path.

Verification
REQ-028 A=64'h0000_0000_0000_FFFF, B=64'h1, cin=0, add -> sum=64'h0000_0000_0001_0000, cout=0, ovf=0, done in cycle 5.
REQ-029 A=64'hFFFF_FFFF_FFFF_FFFF, B=64'h1, add -> sum=64'h0, cout=1, ovf=0.
REQ-030 A=64'h5, B=64'h7, op_sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
REQ-031 A=64'h7FFF_FFFF_FFFF_FFFF, B=64'h1, add -> sum=64'h8000_0000_0000_0000, ovf=1, cout=0; A=B=0, cin=1 -> sum=64'h1.
REQ-032 Pulse start again at cycle 2 of an operation, and change a_in mid-operation -> first result unchanged, one done only.
REQ-033 Assert rst at cycle 3 of an operation -> all outputs 0 at once, no done; a following start of 64'h1+64'h1 -> sum=64'h2.
